sfilt_cmd_seq: RTL and testbench

Command sequencer that drives the serial filter's command interface. It accepts one input sample at a time, keeps a TAPS-deep sample delay line and a TAPS-entry coefficient bank, and emits the full command stream for one FIR output: FIRST, MAC×(TAPS-1), SHIFT, SEND. It sits directly upstream of the serial filter, with pushout/cmd/q/h wired to the filter's pushin/cmd/q/h.

---
 rtl/sfilt_pkg.sv | 22 ++
 rtl/sfilt_cmd_seq_if.sv | 35 +++
 rtl/sfilt_coef_bank.sv | 45 ++++
 rtl/sfilt_cmd_seq.sv | 172 +++++++++++++++++
 tb/tb_sfilt_cmd_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sfilt_pkg.sv
// ---------------------------------------------------------------------------
// sfilt_pkg
// Shared definitions for the serial filter, its command sequencer and benches.
//   CMD_*   : command codes carried on cmd toward the filter
//   state_t : command sequencer FSM state encoding
// ---------------------------------------------------------------------------
package sfilt_pkg;

  localparam logic [1:0] CMD_FIRST = 2'd0;
  localparam logic [1:0] CMD_MAC   = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;
  localparam logic [1:0] CMD_SEND  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    MAC,
    SHIFT,
    SEND
  } state_t;

endpackage

// File: rtl/sfilt_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// sfilt_cmd_seq_if
// Bundles the sequencer's sample input, coefficient write port and the
// command stream toward the serial filter.
//   master : the side that supplies samples/coefficients and consumes commands
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface sfilt_cmd_seq_if #(
  parameter int AW = 6
);

  logic                 sample_push;
  logic signed [31:0]   sample;
  logic                 sample_ready;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [31:0]   coef_data;
  logic [6:0]           shift_amt;
  logic                 pushout;
  logic [1:0]           cmd;
  logic [31:0]          q;
  logic [31:0]          h;
  logic                 busy;

  modport master (
    output sample_push, sample, coef_we, coef_addr, coef_data, shift_amt,
    input  sample_ready, pushout, cmd, q, h, busy
  );

  modport slave (
    input  sample_push, sample, coef_we, coef_addr, coef_data, shift_amt,
    output sample_ready, pushout, cmd, q, h, busy
  );

endinterface

// File: rtl/sfilt_coef_bank.sv
// ---------------------------------------------------------------------------
// sfilt_coef_bank
// TAPS x 32 coefficient register file.
//   clk, rst  : clock, async active-high reset (clears all entries)
//   i_we      : write strobe
//   i_addr    : write index; indices >= TAPS are dropped
//   i_data    : write value
//   i_raddr   : combinational read index (the sequencer's tap counter)
//   o_rdata   : coefficient at i_raddr (0 if out of range)
// ---------------------------------------------------------------------------
module sfilt_coef_bank #(
  parameter int TAPS = 8,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_c [TAPS];

  // Decoding against every legal index means an out-of-range address simply
  // matches nothing, so no separate range check is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_c[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (i_addr == AW'(i)) r_c[i] <= i_data;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (i_raddr == AW'(i)) o_rdata = r_c[i];
    end
  end

endmodule

// File: rtl/sfilt_cmd_seq.sv
// ---------------------------------------------------------------------------
// sfilt_cmd_seq
// Sequences one FIR output on the serial filter per accepted sample:
// FIRST, MAC x (TAPS-1), SHIFT, SEND on consecutive cycles.
//   clk, rst : clock, async active-high reset (also resets filter accumulator)
//   bus      : slave side of sfilt_cmd_seq_if
//              sample_push/sample/sample_ready : sample handshake
//              shift_amt                       : latched on sample acceptance
//              coef_we/coef_addr/coef_data     : coefficient writes
//              pushout/cmd/q/h                 : command stream to the filter
//              busy                            : FIRST, MAC or SHIFT in progress
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no command issued, waiting for a sample
// FIRST | cmd FIRST with newest sample and c[0]
// MAC   | cmd MAC for tap r_tap = 1..TAPS-1
// SHIFT | cmd SHIFT with the latched shift amount in h[6:0]
// SEND  | cmd SEND; a new sample may be accepted here for zero gap
// ---------------------------------------------------------------------------
module sfilt_cmd_seq #(
  parameter int TAPS = 8,
  parameter int AW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  sfilt_cmd_seq_if.slave   bus
);

  import sfilt_pkg::*;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_tap;
  logic [AW-1:0] w_next_tap;
  logic [31:0]   r_x [TAPS];
  logic [6:0]    r_shift;
  logic          w_ready;
  logic          w_accept;
  logic [31:0]   w_x_sel;
  logic [31:0]   w_c_sel;
  logic          w_pushout;
  logic [1:0]    w_cmd;
  logic [31:0]   w_q;
  logic [31:0]   w_h;
  logic          w_busy;

  assign w_ready  = (r_state == IDLE) || (r_state == SEND);
  assign w_accept = bus.sample_push && w_ready;

  sfilt_coef_bank #(
    .TAPS (TAPS),
    .AW   (AW)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (bus.coef_we),
    .i_addr  (bus.coef_addr),
    .i_data  (bus.coef_data),
    .i_raddr (r_tap),
    .o_rdata (w_c_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_x[0] <= bus.sample;
      for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
      r_shift <= bus.shift_amt;
    end
  end

  always_comb begin
    w_x_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (r_tap == AW'(k)) w_x_sel = r_x[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tap   <= '0;
    end else begin
      r_state <= w_next_state;
      r_tap   <= w_next_tap;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_tap   = r_tap;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = FIRST;
          w_next_tap   = '0;
        end
      end
      FIRST: begin
        if (TAPS == 1) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = MAC;
          w_next_tap   = AW'(1);
        end
      end
      MAC: begin
        if (r_tap == AW'(TAPS - 1)) w_next_state = SHIFT;
        else                        w_next_tap   = r_tap + AW'(1);
      end
      SHIFT: w_next_state = SEND;
      SEND: begin
        if (w_accept) begin
          w_next_state = FIRST;
          w_next_tap   = '0;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decode only registered state, tap, delay line and coefficient
  // bank, so FIRST sees whatever c[0] holds during the FIRST cycle itself and
  // the async reset clears the command stream without a clock edge.
  always_comb begin
    w_pushout = 1'b0;
    w_cmd     = CMD_FIRST;
    w_q       = '0;
    w_h       = '0;
    w_busy    = 1'b0;
    case (r_state)
      FIRST: begin
        w_pushout = 1'b1;
        w_cmd     = CMD_FIRST;
        w_q       = w_x_sel;
        w_h       = w_c_sel;
        w_busy    = 1'b1;
      end
      MAC: begin
        w_pushout = 1'b1;
        w_cmd     = CMD_MAC;
        w_q       = w_x_sel;
        w_h       = w_c_sel;
        w_busy    = 1'b1;
      end
      SHIFT: begin
        w_pushout = 1'b1;
        w_cmd     = CMD_SHIFT;
        w_h       = {25'b0, r_shift};
        w_busy    = 1'b1;
      end
      SEND: begin
        w_pushout = 1'b1;
        w_cmd     = CMD_SEND;
      end
      default: ;
    endcase
  end

  assign bus.sample_ready = w_ready;
  assign bus.pushout      = w_pushout;
  assign bus.cmd          = w_cmd;
  assign bus.q            = w_q;
  assign bus.h            = w_h;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_sfilt_cmd_seq.sv
module tb_sfilt_cmd_seq;
  import sfilt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sfilt_cmd_seq_if #(.AW(3)) bus4 ();
  sfilt_cmd_seq_if #(.AW(1)) bus1 ();

  sfilt_cmd_seq #(.TAPS(4), .AW(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  sfilt_cmd_seq #(.TAPS(1), .AW(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mx [4];
  logic [31:0] mc [4];
  logic [6:0]  msh;

  // {pushout, cmd, q, h, busy, sample_ready}
  function automatic logic [68:0] exp_vec(input logic po, input logic [1:0] c,
                                          input logic [31:0] qv, input logic [31:0] hv);
    logic b, r;
    b = po && (c != CMD_SEND);
    r = !po || (c == CMD_SEND);
    return {po, c, qv, hv, b, r};
  endfunction

  function automatic logic [68:0] obs4();
    return {bus4.pushout, bus4.cmd, bus4.q, bus4.h, bus4.busy, bus4.sample_ready};
  endfunction

  function automatic logic [68:0] obs1();
    return {bus1.pushout, bus1.cmd, bus1.q, bus1.h, bus1.busy, bus1.sample_ready};
  endfunction

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input string tag, input logic po, input logic [1:0] c,
                       input logic [31:0] qv, input logic [31:0] hv);
    check(tag, obs4(), exp_vec(po, c, qv, hv));
    tick();
  endtask

  task automatic step1(input string tag, input logic po, input logic [1:0] c,
                       input logic [31:0] qv, input logic [31:0] hv);
    check(tag, obs1(), exp_vec(po, c, qv, hv));
    tick();
  endtask

  task automatic wr4(input logic [2:0] a, input logic [31:0] d);
    bus4.coef_we   = 1'b1;
    bus4.coef_addr = a;
    bus4.coef_data = d;
    tick();
    bus4.coef_we   = 1'b0;
    if (a < 3'd4) mc[a[1:0]] = d;
  endtask

  task automatic model_push(input logic [31:0] s, input logic [6:0] sh);
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    msh   = sh;
  endtask

  task automatic accept4(input logic [31:0] s, input logic [6:0] sh, input bit hold);
    bus4.sample_push = 1'b1;
    bus4.sample      = s;
    bus4.shift_amt   = sh;
    tick();
    if (!hold) bus4.sample_push = 1'b0;
    model_push(s, sh);
  endtask

  // Checks one full TAPS=4 sequence; in the SEND cycle either offers the
  // next sample (keep=1) or drops sample_push.
  task automatic seq4(input string tag, input bit keep, input logic [31:0] nxt);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        if (keep) bus4.sample = nxt;
        else      bus4.sample_push = 1'b0;
      end
      if (k == 0)      step4({tag, "_first"}, 1'b1, CMD_FIRST, mx[0], mc[0]);
      else if (k < 4)  step4({tag, "_mac"},   1'b1, CMD_MAC,   mx[k], mc[k]);
      else if (k == 4) step4({tag, "_shift"}, 1'b1, CMD_SHIFT, 32'd0, {25'd0, msh});
      else             step4({tag, "_send"},  1'b1, CMD_SEND,  32'd0, 32'd0);
    end
    if (keep) model_push(nxt, msh);
  endtask

  initial begin
    bus4.sample_push = 1'b0; bus4.sample = '0; bus4.shift_amt = '0;
    bus4.coef_we = 1'b0; bus4.coef_addr = '0; bus4.coef_data = '0;
    bus1.sample_push = 1'b0; bus1.sample = '0; bus1.shift_amt = '0;
    bus1.coef_we = 1'b0; bus1.coef_addr = '0; bus1.coef_data = '0;
    for (int k = 0; k < 4; k++) begin mx[k] = '0; mc[k] = '0; end
    msh = '0;

    #2;
    check("reset4", obs4(), exp_vec(1'b0, CMD_FIRST, 32'd0, 32'd0));
    check("reset1", obs1(), exp_vec(1'b0, CMD_FIRST, 32'd0, 32'd0));
    #10 rst = 1'b0;
    tick();

    // coefficients 1..4, then an out-of-range write that must not alias c[0]
    wr4(3'd0, 32'd1);
    wr4(3'd1, 32'd2);
    wr4(3'd2, 32'd3);
    wr4(3'd3, 32'd4);
    wr4(3'd4, 32'd99);

    // test 1: sample 5, hand-computed stream
    accept4(32'd5, 7'd0, 1'b0);
    step4("t1_first", 1'b1, CMD_FIRST, 32'd5, 32'd1);
    step4("t1_mac1",  1'b1, CMD_MAC,   32'd0, 32'd2);
    step4("t1_mac2",  1'b1, CMD_MAC,   32'd0, 32'd3);
    step4("t1_mac3",  1'b1, CMD_MAC,   32'd0, 32'd4);
    step4("t1_shift", 1'b1, CMD_SHIFT, 32'd0, 32'd0);
    step4("t1_send",  1'b1, CMD_SEND,  32'd0, 32'd0);
    step4("t1_idle",  1'b0, CMD_FIRST, 32'd0, 32'd0);

    // test 2: sample 7 -> q 7,5,0,0
    accept4(32'd7, 7'd0, 1'b0);
    step4("t2_first", 1'b1, CMD_FIRST, 32'd7, 32'd1);
    step4("t2_mac1",  1'b1, CMD_MAC,   32'd5, 32'd2);
    step4("t2_mac2",  1'b1, CMD_MAC,   32'd0, 32'd3);
    step4("t2_mac3",  1'b1, CMD_MAC,   32'd0, 32'd4);
    step4("t2_shift", 1'b1, CMD_SHIFT, 32'd0, 32'd0);
    step4("t2_send",  1'b1, CMD_SEND,  32'd0, 32'd0);
    step4("t2_idle",  1'b0, CMD_FIRST, 32'd0, 32'd0);

    // test 3: sample_push held, samples 1,2,3 back to back
    accept4(32'd1, 7'd0, 1'b1);
    seq4("t3_s1", 1'b1, 32'd2);
    seq4("t3_s2", 1'b1, 32'd3);
    seq4("t3_s3", 1'b0, 32'd0);
    step4("t3_idle", 1'b0, CMD_FIRST, 32'd0, 32'd0);

    // test 4: c={3,0,0,0}, shift 1, sample 1
    wr4(3'd0, 32'd3);
    wr4(3'd1, 32'd0);
    wr4(3'd2, 32'd0);
    wr4(3'd3, 32'd0);
    accept4(32'd1, 7'd1, 1'b0);
    step4("t4_first", 1'b1, CMD_FIRST, 32'd1, 32'd3);
    step4("t4_mac1",  1'b1, CMD_MAC,   32'd3, 32'd0);
    step4("t4_mac2",  1'b1, CMD_MAC,   32'd2, 32'd0);
    step4("t4_mac3",  1'b1, CMD_MAC,   32'd1, 32'd0);
    step4("t4_shift", 1'b1, CMD_SHIFT, 32'd0, 32'd1);
    step4("t4_send",  1'b1, CMD_SEND,  32'd0, 32'd0);
    step4("t4_idle",  1'b0, CMD_FIRST, 32'd0, 32'd0);

    // test 5: reset during the second MAC cycle
    accept4(32'd4, 7'd0, 1'b0);
    step4("t5_first", 1'b1, CMD_FIRST, 32'd4, 32'd3);
    step4("t5_mac1",  1'b1, CMD_MAC,   32'd1, 32'd0);
    check("t5_pre_rst", obs4(), exp_vec(1'b1, CMD_MAC, 32'd3, 32'd0));
    rst = 1'b1;
    #1;
    check("t5_async_rst", obs4(), exp_vec(1'b0, CMD_FIRST, 32'd0, 32'd0));
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin mx[k] = '0; mc[k] = '0; end
    msh = '0;
    tick();
    wr4(3'd0, 32'd1);
    wr4(3'd1, 32'd2);
    wr4(3'd2, 32'd3);
    wr4(3'd3, 32'd4);
    accept4(32'd6, 7'd0, 1'b0);
    step4("t5_first2", 1'b1, CMD_FIRST, 32'd6, 32'd1);
    step4("t5_mac1b",  1'b1, CMD_MAC,   32'd0, 32'd2);
    step4("t5_mac2b",  1'b1, CMD_MAC,   32'd0, 32'd3);
    step4("t5_mac3b",  1'b1, CMD_MAC,   32'd0, 32'd4);
    step4("t5_shift2", 1'b1, CMD_SHIFT, 32'd0, 32'd0);
    step4("t5_send2",  1'b1, CMD_SEND,  32'd0, 32'd0);
    step4("t5_idle2",  1'b0, CMD_FIRST, 32'd0, 32'd0);

    // test 6: TAPS=1, c[0]=2 with an ignored write to index 1, sample 9
    bus1.coef_we = 1'b1; bus1.coef_addr = 1'b0; bus1.coef_data = 32'd2;
    tick();
    bus1.coef_addr = 1'b1; bus1.coef_data = 32'd5;
    tick();
    bus1.coef_we = 1'b0;
    bus1.sample_push = 1'b1; bus1.sample = 32'd9; bus1.shift_amt = 7'd0;
    tick();
    bus1.sample_push = 1'b0;
    step1("t6_first", 1'b1, CMD_FIRST, 32'd9, 32'd2);
    step1("t6_shift", 1'b1, CMD_SHIFT, 32'd0, 32'd0);
    step1("t6_send",  1'b1, CMD_SEND,  32'd0, 32'd0);
    step1("t6_idle",  1'b0, CMD_FIRST, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
